output_fm: RTL and testbench
============================

OUTPUT_FM -- requirements
Module: output_fm

Interface
REQ-001 Parameters (name, default, meaning), one per line: AW 16 bank address width; DW 32 data width; Tm 16 output-channel tile size, multiple of 4; Tr 64 tile rows; Tc 16 tile cols.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wr_data0..wr_data3  input  DW each  compute-side write data, bank 0..3.
REQ-005 wr_addr0..wr_addr3  input  AW each  compute-side write address, bank 0..3.
REQ-006 wr_ena0..wr_ena3  input  1 each  compute-side write strobe, bank 0..3.
REQ-007 out_fm_store_start  input  1  one-cycle pulse; begin draining the tile.
REQ-008 out_fm_store_done  output  1  one-cycle pulse; last word pushed.
REQ-009 out_fm_store_busy  output  1  high while a drain is in progress.
REQ-010 out_fm_fifo_data  output  DW  data toward the output FIFO.
REQ-011 out_fm_fifo_push  output  1  push strobe; a word transfers when push=1.
REQ-012 out_fm_fifo_full  input  1  FIFO full; push is never asserted while full=1.

Function
REQ-013 Four independent banks, each of depth Tm/4*Tr*Tc words, 1 write port and 1 read port, synchronous read with 1-cycle latency, read-first on same-address collision.
REQ-014 Write port: if wr_enaK=1, bankK[wr_addrK] <= wr_dataK; writes are accepted in every cycle, including during a drain.
REQ-015 Layout: S = Tr*Tc; output channel m resides in bank m mod 4, addresses (m/4)*S .. (m/4)*S+S-1, row-major.
REQ-016 Drain order: channels 0..Tm-1 in sequence, words 0..S-1 within each channel; total N = Tm*Tr*Tc pushes.
REQ-017 Read generator: a bank-select one-hot (reset 4'b0001) rotates left after each S reads; the base address advances by S after every 4th slice; a word counter over N stops issue at N.
REQ-018 Buffering: 2-entry output skid buffer; a read issues in cycle t only if busy, reads remain, and (buf_count + rd_inflight - push_t) < 2; the returned word enters the buffer at t+1.
REQ-019 Push rule: out_fm_fifo_push = buffer non-empty AND out_fm_fifo_full=0; out_fm_fifo_data = buffer head (combinational from the head register); head is dequeued on push.
REQ-020 Throughput: with full=0 steadily, one push per cycle; first push 2 cycles after start (start at t, first read t+1, push t+2); last push at t+N+1.
REQ-021 States: IDLE -> (start) RUN -> (N-th push) IDLE; busy=1 in RUN; done pulses in the cycle after the N-th push; busy drops in the same cycle.
REQ-022 start in RUN is ignored; start and the N-th push in the same cycle: start ignored, done still pulses.
REQ-023 full asserted mid-drain: push=0, buffer holds, reads stop once 2 words are held or in flight; no word is lost or duplicated; resume on full=0.
REQ-024 Counters are wide enough for N without wrap; after completion all read-side counters, bank-select, and base return to initial values.

Reset
REQ-025 rst=1 at any clock edge: state IDLE, out_fm_store_busy=0, out_fm_store_done=0, out_fm_fifo_push=0, buffer empty, rd_inflight=0, counters 0, bank-select 4'b0001; a drain in progress is abandoned.
REQ-026 Bank contents are not reset; out_fm_fifo_data is don't-care while push=0.

Verification (Tm=4, Tr=2, Tc=2: S=4, N=16; preload bankK[a] = 16*K + a)
REQ-027 Full=0, start at cycle 10 -> pushes on cycles 12..27 with data 0,1,2,3,16,17,18,19,32,..,51; done pulses at 28.
REQ-028 Tm=8, same fill pattern plus bankK[a], a=4..7 -> channel 4 drains bank0 addr 4..7 (data 4..7) immediately after channel 3.
REQ-029 full=1 for cycles 14..19 -> no push during 14..19; sequence unchanged; done is delayed by 6 cycles.
REQ-030 full toggling every cycle -> exactly 16 pushes, in order, never with full=1.
REQ-031 Second start at cycle 15 during a drain -> ignored; a single done; a new start after done repeats the identical sequence.
REQ-032 rst at cycle 18 mid-drain -> push/busy/done low the next cycle; a fresh start then drains from word 0.

Source files
------------

// File: rtl/output_fm.sv
// -----------------------------------------------------------------------------
// output_fm -- four-bank output feature-map buffer with a streaming drain.
//
// The compute side writes results into four independent banks. A start pulse
// drains the whole tile to an output FIFO, channel by channel. Channel m lives
// in bank m mod 4 at addresses (m/4)*S .. (m/4)*S+S-1 with S = Tr*Tc.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   wr_data0..3 / wr_addr0..3  compute-side write port of each bank
//   wr_ena0..3                 write strobe of each bank
//   out_fm_store_start         one-cycle pulse, begin the drain (ignored when busy)
//   out_fm_store_done          one-cycle pulse, cycle after the last push
//   out_fm_store_busy          high while the drain is running
//   out_fm_fifo_data/_push     word toward the FIFO, transfers when push=1
//   out_fm_fifo_full           FIFO full, push is held low while set
// -----------------------------------------------------------------------------
module output_fm #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wr_data0,
    input  logic [DW-1:0] wr_data1,
    input  logic [DW-1:0] wr_data2,
    input  logic [DW-1:0] wr_data3,
    input  logic [AW-1:0] wr_addr0,
    input  logic [AW-1:0] wr_addr1,
    input  logic [AW-1:0] wr_addr2,
    input  logic [AW-1:0] wr_addr3,
    input  logic          wr_ena0,
    input  logic          wr_ena1,
    input  logic          wr_ena2,
    input  logic          wr_ena3,
    input  logic          out_fm_store_start,
    output logic          out_fm_store_done,
    output logic          out_fm_store_busy,
    output logic [DW-1:0] out_fm_fifo_data,
    output logic          out_fm_fifo_push,
    input  logic          out_fm_fifo_full
);

    localparam int S  = Tr * Tc;            // words per channel slice
    localparam int D  = (Tm / 4) * S;       // words per bank
    localparam int N  = Tm * S;             // words per drain
    localparam int BW = (D > 1) ? $clog2(D) : 1;
    localparam int SW = (S > 1) ? $clog2(S) : 1;
    localparam int NW = $clog2(N + 1);

    localparam logic [NW-1:0] N_W        = NW'(N);
    localparam logic [NW-1:0] N_LAST     = NW'(N - 1);
    localparam logic [SW-1:0] SLICE_LAST = SW'(S - 1);
    localparam logic [BW-1:0] S_STEP     = BW'(S);
    localparam logic [AW:0]   DEPTH      = (AW+1)'(D);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic          busy;

    logic [DW-1:0] wr_data_a [4];
    logic [AW-1:0] wr_addr_a [4];
    logic [3:0]    wr_ena_a;
    logic [DW-1:0] rd_word   [4];

    logic [3:0]    bank_sel_q, bank_sel_d, rd_bank_q;
    logic [BW-1:0] base_q, base_d, rd_addr;
    logic [SW-1:0] slice_q, slice_d;
    logic [NW-1:0] rd_cnt_q, rd_cnt_d, push_cnt_q, push_cnt_d;
    logic          rd_inflight_q;
    logic [1:0]    buf_cnt_q, buf_cnt_d;
    logic [DW-1:0] buf0_q, buf1_q, buf0_d, buf1_d;
    logic          done_q;

    logic [2:0]    occ;
    logic          push, last_push, rd_issue;
    logic [DW-1:0] ret_word, q0, q1;

    assign wr_data_a[0] = wr_data0;
    assign wr_data_a[1] = wr_data1;
    assign wr_data_a[2] = wr_data2;
    assign wr_data_a[3] = wr_data3;
    assign wr_addr_a[0] = wr_addr0;
    assign wr_addr_a[1] = wr_addr1;
    assign wr_addr_a[2] = wr_addr2;
    assign wr_addr_a[3] = wr_addr3;
    assign wr_ena_a     = {wr_ena3, wr_ena2, wr_ena1, wr_ena0};

    // ---------------------------------------------------------------- banks
    // Registered read, read-first on a same-address collision (the read
    // samples the array before the non-blocking write lands). Writes beyond
    // the bank depth are dropped rather than aliased.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            logic [DW-1:0] mem [0:D-1];
            logic [DW-1:0] rd_data_q;

            always_ff @(posedge clk) begin
                if (wr_ena_a[gi] && ({1'b0, wr_addr_a[gi]} < DEPTH)) begin
                    mem[wr_addr_a[gi][BW-1:0]] <= wr_data_a[gi];
                end
                if (rd_issue && bank_sel_q[gi]) begin
                    rd_data_q <= mem[rd_addr];
                end
            end

            assign rd_word[gi] = rd_data_q;
        end
    endgenerate

    // Word returning this cycle from the bank read one cycle ago.
    always_comb begin
        ret_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (rd_bank_q[k]) begin
                ret_word = ret_word | rd_word[k];
            end
        end
    end

    // ------------------------------------------------------- skid buffer
    // The returning word is treated as the tail entry of the buffer in its
    // arrival cycle, so it can be pushed straight through; occ counts held
    // words plus that arriving word and never exceeds 2.
    assign occ       = 3'(buf_cnt_q) + 3'(rd_inflight_q);
    assign push      = (occ != 3'd0) && !out_fm_fifo_full;
    assign last_push = push && (push_cnt_q == N_LAST);
    assign rd_issue  = busy && (rd_cnt_q != N_W) && ((occ - 3'(push)) < 3'd2);
    assign rd_addr   = base_q + BW'(slice_q);

    always_comb begin
        q0        = (buf_cnt_q != 2'd0) ? buf0_q : ret_word;
        q1        = (buf_cnt_q == 2'd2) ? buf1_q : ret_word;
        buf0_d    = push ? q1 : q0;
        buf1_d    = q1;
        buf_cnt_d = 2'(occ - 3'(push));
    end

    // -------------------------------------------------- read generator
    always_comb begin
        bank_sel_d = bank_sel_q;
        base_d     = base_q;
        slice_d    = slice_q;
        rd_cnt_d   = rd_cnt_q;
        push_cnt_d = push_cnt_q;
        if (last_push) begin
            // Drain complete: return every read-side counter to its start.
            bank_sel_d = 4'b0001;
            base_d     = '0;
            slice_d    = '0;
            rd_cnt_d   = '0;
            push_cnt_d = '0;
        end else begin
            if (rd_issue) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (slice_q == SLICE_LAST) begin
                    slice_d    = '0;
                    bank_sel_d = {bank_sel_q[2:0], bank_sel_q[3]};
                    // Four slices (one per bank) share one base address.
                    if (bank_sel_q[3]) begin
                        base_d = base_q + S_STEP;
                    end
                end else begin
                    slice_d = slice_q + 1'b1;
                end
            end
            if (push) begin
                push_cnt_d = push_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (out_fm_store_start) state_d = RUN;
            RUN:     if (last_push)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    // ------------------------------------------------- control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_q    <= 4'b0001;
            rd_bank_q     <= 4'b0001;
            base_q        <= '0;
            slice_q       <= '0;
            rd_cnt_q      <= '0;
            push_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            buf_cnt_q     <= 2'd0;
            done_q        <= 1'b0;
        end else begin
            bank_sel_q    <= bank_sel_d;
            base_q        <= base_d;
            slice_q       <= slice_d;
            rd_cnt_q      <= rd_cnt_d;
            push_cnt_q    <= push_cnt_d;
            rd_inflight_q <= rd_issue;
            buf_cnt_q     <= buf_cnt_d;
            done_q        <= last_push;
            if (rd_issue) begin
                rd_bank_q <= bank_sel_q;
            end
        end
    end

    // Buffer payload needs no reset: it is only observed when occupancy says so.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign out_fm_fifo_data  = q0;
    assign out_fm_fifo_push  = push;
    assign out_fm_store_busy = busy;
    assign out_fm_store_done = done_q;

endmodule

// File: tb/tb_output_fm.sv
// -----------------------------------------------------------------------------
// tb_output_fm -- self-checking bench for output_fm (Tm=8, Tr=2, Tc=2).
// A bank image model produces the expected drain stream channel by channel;
// a negedge monitor checks every pushed word, push-vs-full and done timing.
// -----------------------------------------------------------------------------
module tb_output_fm;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TM = 8;
    localparam int TR = 2;
    localparam int TC = 2;
    localparam int S  = TR * TC;
    localparam int D  = (TM / 4) * S;
    localparam int N  = TM * S;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] wr_data [4];
    logic [AW-1:0] wr_addr [4];
    logic          wr_ena  [4];
    logic          start, done, busy, push, full;
    logic [DW-1:0] fdata;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    output_fm #(.AW(AW), .DW(DW), .Tm(TM), .Tr(TR), .Tc(TC)) dut (
        .clk                (clk),
        .rst                (rst),
        .wr_data0           (wr_data[0]),
        .wr_data1           (wr_data[1]),
        .wr_data2           (wr_data[2]),
        .wr_data3           (wr_data[3]),
        .wr_addr0           (wr_addr[0]),
        .wr_addr1           (wr_addr[1]),
        .wr_addr2           (wr_addr[2]),
        .wr_addr3           (wr_addr[3]),
        .wr_ena0            (wr_ena[0]),
        .wr_ena1            (wr_ena[1]),
        .wr_ena2            (wr_ena[2]),
        .wr_ena3            (wr_ena[3]),
        .out_fm_store_start (start),
        .out_fm_store_done  (done),
        .out_fm_store_busy  (busy),
        .out_fm_fifo_data   (fdata),
        .out_fm_fifo_push   (push),
        .out_fm_fifo_full   (full)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ model
    logic [DW-1:0] model_mem [4][D];
    logic [DW-1:0] exp_q [$];

    function automatic void build_expected();
        exp_q.delete();
        for (int m = 0; m < TM; m++) begin
            for (int w = 0; w < S; w++) begin
                exp_q.push_back(model_mem[m % 4][(m / 4) * S + w]);
            end
        end
    endfunction

    // ---------------------------------------------------------- monitor
    int push_seen      = 0;
    int done_seen      = 0;
    int first_push_cyc = -1;
    int done_cyc       = -1;

    always @(negedge clk) begin
        if (!rst) begin
            if (push) begin
                $display("push cyc=%0d data=%08h", cyc, fdata);
                chk("push_while_full", full, 0);
                if (exp_q.size() == 0) begin
                    chk("extra_push", 1, 0);
                end else begin
                    chk($sformatf("data[%0d]", push_seen), fdata, exp_q.pop_front());
                end
                if (push_seen == 0) first_push_cyc = cyc;
                push_seen++;
            end
            if (done) begin
                $display("done cyc=%0d", cyc);
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_banks(input bit rnd);
        for (int a = 0; a < D; a++) begin
            for (int k = 0; k < 4; k++) begin
                logic [DW-1:0] v;
                v = rnd ? DW'($urandom) : DW'(16 * k + a);
                wr_ena[k]  = 1'b1;
                wr_addr[k] = AW'(a);
                wr_data[k] = v;
                model_mem[k][a] = v;
            end
            tick();
        end
        for (int k = 0; k < 4; k++) wr_ena[k] = 1'b0;
    endtask

    function automatic logic full_for(input int mode, input int rel);
        case (mode)
            1:       return (rel >= 4 && rel <= 9);
            2:       return rel[0];
            3:       return ($urandom_range(0, 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    // mode: 0 full=0, 1 full during rel 4..9, 2 toggling, 3 random.
    // exp_done_rel < 0 skips the cycle-exact timing checks.
    task automatic run_drain(input int mode, input int second_start_rel, input int exp_done_rel);
        int t0, guard, rel;
        build_expected();
        push_seen = 0; done_seen = 0; first_push_cyc = -1; done_cyc = -1;
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (done_seen == 0 && guard < 1000) begin
            rel = cyc - t0;
            if (rel == 1) chk("busy_run", busy, 1);
            full  = full_for(mode, rel);
            start = (rel == second_start_rel);
            tick();
            guard++;
        end
        start = 1'b0;
        full  = 1'b0;
        chk("done_before_timeout", done_seen, 1);
        repeat (4) tick();
        chk("single_done", done_seen, 1);
        chk("push_count", push_seen, N);
        chk("all_words_out", exp_q.size(), 0);
        chk("busy_after", busy, 0);
        if (exp_done_rel >= 0) begin
            chk("first_push_cyc", first_push_cyc, t0 + 2);
            chk("done_cyc", done_cyc, t0 + exp_done_rel);
        end
    endtask

    // ------------------------------------------------------------ main
    initial begin
        rst = 1'b1; start = 1'b0; full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_ena[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_push", push, 0);

        load_banks(1'b0);

        run_drain(0, -1, N + 2);       // plain drain, channel 4 follows channel 3
        run_drain(1, -1, N + 8);       // six full cycles delay done by six
        run_drain(2, -1, -1);          // full toggling every cycle
        run_drain(0, 5, N + 2);        // second start mid-drain ignored
        run_drain(0, -1, N + 2);       // a new start repeats the sequence
        run_drain(0, N + 1, N + 2);    // start together with the last push

        // Reset in the middle of a drain, then a fresh drain from word 0.
        build_expected();
        push_seen = 0; done_seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_push", push, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_prefix_pushes", push_seen > 0, 1);
        tick();
        chk("midrst_no_done", done_seen, 0);
        run_drain(0, -1, N + 2);

        // Random bank contents with random back-pressure.
        for (int r = 0; r < 4; r++) begin
            load_banks(1'b1);
            run_drain(3, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
